// File: rtl/pc_unit.sv
// Program-counter unit: holds the PC, selects the next PC from sequential,
// branch, jump, call and return flows, and keeps a small return-address stack.
module pc_unit #(
    parameter int WIDTH    = 16,
    parameter int INC      = 2,
    parameter int OFF_W    = 8,
    parameter int DEPTH    = 4,
    parameter int RESET_PC = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [2:0]       MODE,
    input  logic             COND,
    input  logic [OFF_W-1:0] OFFSET,
    input  logic [WIDTH-1:0] TARGET,
    output logic [WIDTH-1:0] PCOUT,
    output logic [WIDTH-1:0] LINK,
    output logic [WIDTH-1:0] RA_TOP,
    output logic             STK_EMPTY,
    output logic             STK_FULL,
    output logic             STK_ERR
);

    // Count needs to represent 0..DEPTH; entry index only 0..DEPTH-1.
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SLOTS = 2 ** AW;

    typedef enum logic [2:0] {
        MODE_SEQ  = 3'b000,
        MODE_BR   = 3'b001,
        MODE_JMP  = 3'b010,
        MODE_CALL = 3'b011,
        MODE_RET  = 3'b100
    } mode_e;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] stk_q [SLOTS];
    logic [WIDTH-1:0] stk_d [SLOTS];

    logic [WIDTH-1:0] off_ext;
    logic [WIDTH-1:0] br_tgt;
    logic [AW-1:0]    push_idx;
    logic [AW-1:0]    top_idx;

    // Derived values: link address, branch target and stack pointers.
    always_comb begin
        LINK      = pc_q + WIDTH'(INC);
        off_ext   = WIDTH'($signed(OFFSET));
        br_tgt    = pc_q + (off_ext << 1);
        STK_EMPTY = (cnt_q == '0);
        STK_FULL  = (cnt_q == CW'(DEPTH));
        // Index arithmetic wraps modulo SLOTS; valid because count-1 < DEPTH <= SLOTS.
        push_idx  = cnt_q[AW-1:0];
        top_idx   = cnt_q[AW-1:0] - AW'(1);
        RA_TOP    = STK_EMPTY ? '0 : stk_q[top_idx];
        PCOUT     = pc_q;
        STK_ERR   = err_q;
    end

    // Next-state selection for PC, stack and error flag.
    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        err_d = err_q;
        stk_d = stk_q;
        if (EN) begin
            case (mode_e'(MODE))
                MODE_SEQ: pc_d = LINK;
                MODE_BR:  pc_d = COND ? br_tgt : LINK;
                MODE_JMP: pc_d = TARGET;
                MODE_CALL: begin
                    pc_d = TARGET;
                    if (STK_FULL) begin
                        err_d = 1'b1;
                    end else begin
                        stk_d[push_idx] = LINK;
                        cnt_d           = cnt_q + CW'(1);
                    end
                end
                MODE_RET: begin
                    if (STK_EMPTY) begin
                        pc_d  = LINK;
                        err_d = 1'b1;
                    end else begin
                        pc_d  = RA_TOP;
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: begin
                    pc_d  = LINK;
                    err_d = 1'b1;
                end
            endcase
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q  <= WIDTH'(RESET_PC);
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Stack entry storage; contents are meaningless once count is reset.
    always_ff @(posedge CLK) begin
        stk_q <= stk_d;
    end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed vector table plus randomized
// stimulus against a queue-based reference model.
module tb_pc_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        EN;
    logic [2:0]  MODE;
    logic        COND;
    logic [7:0]  OFFSET;
    logic [15:0] TARGET;
    logic [15:0] PCOUT, LINK, RA_TOP;
    logic        STK_EMPTY, STK_FULL, STK_ERR;

    int n_vec = 0;
    int n_err = 0;

    pc_unit #(
        .WIDTH(16), .INC(2), .OFF_W(8), .DEPTH(4), .RESET_PC(0)
    ) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .MODE(MODE), .COND(COND),
        .OFFSET(OFFSET), .TARGET(TARGET), .PCOUT(PCOUT), .LINK(LINK),
        .RA_TOP(RA_TOP), .STK_EMPTY(STK_EMPTY), .STK_FULL(STK_FULL),
        .STK_ERR(STK_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic        en;
        logic [2:0]  mode;
        logic        cond;
        logic [7:0]  off;
        logic [15:0] tgt;
        logic [15:0] pc;
        logic [15:0] ra;
        logic        empty;
        logic        full;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic en, input logic [2:0] mode,
                       input logic cond, input logic [7:0] off, input logic [15:0] tgt,
                       input logic [15:0] pc, input logic [15:0] ra,
                       input logic empty, input logic full, input logic err);
        vec_t v;
        v.rst = rst; v.en = en; v.mode = mode; v.cond = cond; v.off = off; v.tgt = tgt;
        v.pc = pc; v.ra = ra; v.empty = empty; v.full = full; v.err = err;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic check_outs(input int idx, input logic [15:0] pc, input logic [15:0] ra,
                              input logic empty, input logic full, input logic err);
        logic [15:0] lk;
        lk = pc + 16'd2;
        chk("PCOUT", idx, PCOUT, pc);
        chk("LINK", idx, LINK, lk);
        chk("RA_TOP", idx, RA_TOP, ra);
        chk("STK_EMPTY", idx, {15'd0, STK_EMPTY}, {15'd0, empty});
        chk("STK_FULL", idx, {15'd0, STK_FULL}, {15'd0, full});
        chk("STK_ERR", idx, {15'd0, STK_ERR}, {15'd0, err});
    endtask

    task automatic drive(input logic rst, input logic en, input logic [2:0] mode,
                         input logic cond, input logic [7:0] off, input logic [15:0] tgt);
        RST = rst; EN = en; MODE = mode; COND = cond; OFFSET = off; TARGET = tgt;
        @(posedge CLK);
        #1;
    endtask

    // Reference model state
    logic [15:0] m_pc;
    logic [15:0] m_stk[$];
    logic        m_err;

    task automatic model_step(input logic rst, input logic en, input logic [2:0] mode,
                              input logic cond, input logic [7:0] off, input logic [15:0] tgt);
        int soff;
        if (rst) begin
            m_pc = 16'h0000;
            m_stk.delete();
            m_err = 1'b0;
        end else if (en) begin
            soff = int'($signed(off));
            if (mode == 3'd0) m_pc = m_pc + 16'd2;
            else if (mode == 3'd1) m_pc = cond ? 16'(int'(m_pc) + 2 * soff) : m_pc + 16'd2;
            else if (mode == 3'd2) m_pc = tgt;
            else if (mode == 3'd3) begin
                if (m_stk.size() >= 4) m_err = 1'b1;
                else m_stk.push_back(m_pc + 16'd2);
                m_pc = tgt;
            end else if (mode == 3'd4) begin
                if (m_stk.size() == 0) begin
                    m_err = 1'b1;
                    m_pc  = m_pc + 16'd2;
                end else begin
                    m_pc = m_stk.pop_back();
                end
            end else begin
                m_pc  = m_pc + 16'd2;
                m_err = 1'b1;
            end
        end
    endtask

    initial begin
        RST = 1'b1; EN = 1'b0; MODE = 3'd0; COND = 1'b0; OFFSET = '0; TARGET = '0;

        //   rst en mode c  off    tgt       pc        ra       e  f  err
        add(1, 0, 3'd0, 0, 8'h00, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0);
        add(0, 1, 3'd0, 0, 8'h00, 16'h0000, 16'h0002, 16'h0000, 1, 0, 0);
        add(0, 1, 3'd0, 0, 8'h00, 16'h0000, 16'h0004, 16'h0000, 1, 0, 0);
        add(0, 1, 3'd0, 0, 8'h00, 16'h0000, 16'h0006, 16'h0000, 1, 0, 0);
        add(0, 1, 3'd0, 0, 8'h00, 16'h0000, 16'h0008, 16'h0000, 1, 0, 0);
        add(0, 1, 3'd0, 0, 8'h00, 16'h0000, 16'h000A, 16'h0000, 1, 0, 0);
        add(0, 1, 3'd2, 0, 8'h00, 16'h0010, 16'h0010, 16'h0000, 1, 0, 0);
        add(0, 1, 3'd1, 1, 8'hFC, 16'h0000, 16'h0008, 16'h0000, 1, 0, 0);
        add(0, 1, 3'd2, 0, 8'h00, 16'h0010, 16'h0010, 16'h0000, 1, 0, 0);
        add(0, 1, 3'd1, 0, 8'hFC, 16'h0000, 16'h0012, 16'h0000, 1, 0, 0);
        add(0, 1, 3'd2, 0, 8'h00, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0);
        add(0, 1, 3'd1, 1, 8'h7F, 16'h0000, 16'h00FE, 16'h0000, 1, 0, 0);
        add(0, 0, 3'd2, 0, 8'h00, 16'h1234, 16'h00FE, 16'h0000, 1, 0, 0);
        add(0, 0, 3'd2, 0, 8'h00, 16'h1234, 16'h00FE, 16'h0000, 1, 0, 0);
        add(0, 0, 3'd2, 0, 8'h00, 16'h1234, 16'h00FE, 16'h0000, 1, 0, 0);
        add(0, 1, 3'd2, 0, 8'h00, 16'h1234, 16'h1234, 16'h0000, 1, 0, 0);
        add(0, 1, 3'd2, 0, 8'h00, 16'h0020, 16'h0020, 16'h0000, 1, 0, 0);
        add(0, 1, 3'd3, 0, 8'h00, 16'h0100, 16'h0100, 16'h0022, 0, 0, 0);
        add(0, 1, 3'd3, 0, 8'h00, 16'h0200, 16'h0200, 16'h0102, 0, 0, 0);
        add(0, 1, 3'd4, 0, 8'h00, 16'h0000, 16'h0102, 16'h0022, 0, 0, 0);
        add(0, 1, 3'd4, 0, 8'h00, 16'h0000, 16'h0022, 16'h0000, 1, 0, 0);
        add(0, 1, 3'd3, 0, 8'h00, 16'h0300, 16'h0300, 16'h0024, 0, 0, 0);
        add(0, 1, 3'd3, 0, 8'h00, 16'h0400, 16'h0400, 16'h0302, 0, 0, 0);
        add(0, 1, 3'd3, 0, 8'h00, 16'h0500, 16'h0500, 16'h0402, 0, 0, 0);
        add(0, 1, 3'd3, 0, 8'h00, 16'h0600, 16'h0600, 16'h0502, 0, 1, 0);
        add(0, 1, 3'd3, 0, 8'h00, 16'h0700, 16'h0700, 16'h0502, 0, 1, 1);
        add(0, 1, 3'd4, 0, 8'h00, 16'h0000, 16'h0502, 16'h0402, 0, 0, 1);
        add(0, 1, 3'd4, 0, 8'h00, 16'h0000, 16'h0402, 16'h0302, 0, 0, 1);
        add(0, 1, 3'd4, 0, 8'h00, 16'h0000, 16'h0302, 16'h0024, 0, 0, 1);
        add(0, 1, 3'd4, 0, 8'h00, 16'h0000, 16'h0024, 16'h0000, 1, 0, 1);
        add(0, 1, 3'd4, 0, 8'h00, 16'h0000, 16'h0026, 16'h0000, 1, 0, 1);
        add(0, 0, 3'd4, 0, 8'h00, 16'h0000, 16'h0026, 16'h0000, 1, 0, 1);
        add(1, 1, 3'd0, 0, 8'h00, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0);
        add(0, 0, 3'd6, 0, 8'h00, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0);
        add(0, 1, 3'd5, 0, 8'h00, 16'h0000, 16'h0002, 16'h0000, 1, 0, 1);
        add(1, 1, 3'd0, 0, 8'h00, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0);
        add(0, 1, 3'd2, 0, 8'h00, 16'hFFFE, 16'hFFFE, 16'h0000, 1, 0, 0);
        add(0, 1, 3'd0, 0, 8'h00, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0);
        add(0, 1, 3'd3, 0, 8'h00, 16'h0040, 16'h0040, 16'h0002, 0, 0, 0);
        add(0, 1, 3'd3, 0, 8'h00, 16'h0055, 16'h0055, 16'h0042, 0, 0, 0);
        add(1, 1, 3'd3, 0, 8'h00, 16'h0080, 16'h0000, 16'h0000, 1, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].cond, vecs[i].off, vecs[i].tgt);
            check_outs(i, vecs[i].pc, vecs[i].ra, vecs[i].empty, vecs[i].full, vecs[i].err);
        end

        // Randomized phase; first cycle resets so model and DUT start aligned.
        for (int i = 0; i < 600; i++) begin
            logic        r_rst, r_en, r_cond;
            logic [2:0]  r_mode;
            logic [7:0]  r_off;
            logic [15:0] r_tgt;
            logic [15:0] e_ra;
            r_rst  = (i == 0) || ($urandom_range(0, 63) == 0);
            r_en   = ($urandom_range(0, 9) < 8);
            r_mode = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(5, 7))
                                                   : 3'($urandom_range(0, 4));
            r_cond = 1'($urandom_range(0, 1));
            r_off  = 8'($urandom);
            r_tgt  = 16'($urandom);
            model_step(r_rst, r_en, r_mode, r_cond, r_off, r_tgt);
            drive(r_rst, r_en, r_mode, r_cond, r_off, r_tgt);
            e_ra = (m_stk.size() == 0) ? 16'h0000 : m_stk[m_stk.size() - 1];
            check_outs(1000 + i, m_pc, e_ra, m_stk.size() == 0, m_stk.size() == 4, m_err);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter unit, successor to the fixed +2 PC adder. Holds the PC register and selects next PC from sequential increment, PC-relative branch, absolute jump, call and return. Includes a small hardware return-address stack. Sits between control unit (MODE/COND/EN) and instruction memory address port (PCOUT).

Parameters:
WIDTH, 16, PC and address width in bits
INC, 2, sequential increment in bytes (instruction size)
OFF_W, 8, width of signed branch offset field
DEPTH, 4, return-address stack entries (>=1)
RESET_PC, 0, PC value loaded on reset

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  synchronous reset, active-high
EN  in  1  advance enable; 0 = hold all state (stall)
MODE  in  3  000 SEQ, 001 BR, 010 JMP, 011 CALL, 100 RET, 101-111 illegal
COND  in  1  branch condition, used only in BR
OFFSET  in  OFF_W  signed branch offset in instruction halfwords
TARGET  in  WIDTH  absolute jump/call target
PCOUT  out  WIDTH  current PC (registered)
LINK  out  WIDTH  PCOUT + INC (combinational, mod 2^WIDTH)
RA_TOP  out  WIDTH  top-of-stack return address; 0 when empty
STK_EMPTY  out  1  stack holds 0 entries
STK_FULL  out  1  stack holds DEPTH entries
STK_ERR  out  1  sticky error flag

Behaviour:
- Reset (RST=1 at edge): PCOUT<=RESET_PC, stack count<=0, STK_ERR<=0; entries need not clear. RST overrides EN and MODE. Reset mid-sequence discards all pending stack contents.
- Outputs after reset: PCOUT=RESET_PC, LINK=RESET_PC+INC, RA_TOP=0, STK_EMPTY=1, STK_FULL=0, STK_ERR=0.
- EN=0: PCOUT, stack, STK_ERR unchanged; MODE ignored.
- EN=1, latency one cycle; new PCOUT visible after the edge:
  - SEQ: PCOUT<=PCOUT+INC.
  - BR: COND=1 -> PCOUT<=PCOUT+(sext(OFFSET)<<1); COND=0 -> PCOUT+INC.
  - JMP: PCOUT<=TARGET.
  - CALL: push LINK, PCOUT<=TARGET. If STK_FULL: no push, stack unchanged, PCOUT<=TARGET, STK_ERR<=1.
  - RET: PCOUT<=RA_TOP, pop. If STK_EMPTY: PCOUT<=PCOUT+INC, STK_ERR<=1.
  - Illegal MODE: treated as SEQ, STK_ERR<=1.
- Arithmetic: all sums truncated to WIDTH bits (wrap-around, no saturation, no carry flag). OFFSET sign-extended to WIDTH before shift.
- Stack: LIFO, count 0..DEPTH; STK_FULL/STK_EMPTY decoded from registered count. Only one push or pop per cycle.
- STK_ERR: sticky, cleared only by RST.
- TARGET and stacked values used unmodified (no alignment forcing).

Test Plan:
- Reset then 5 cycles SEQ, EN=1 -> PCOUT 0,2,4,6,8,10; LINK always PCOUT+2.
- PCOUT=0x0010, BR OFFSET=0xFC (-4), COND=1 -> 0x0008; same with COND=0 -> 0x0012; OFFSET=0x7F from 0x0000 -> 0x00FE.
- EN=0 for 3 cycles with MODE=JMP TARGET=0x1234 -> PCOUT held; EN=1 -> 0x1234.
- CALL 0x0100 from 0x0020, CALL 0x0200 -> RA_TOP=0x0102, then RET -> 0x0102, RET -> 0x0022, STK_EMPTY=1, STK_ERR=0.
- DEPTH=4: 5 CALLs -> STK_FULL=1 after 4th, 5th jumps without push, STK_ERR=1; 5 RETs -> 5th from empty gives PC+2, STK_ERR stays 1 until RST.
- PCOUT=0xFFFE SEQ -> 0x0000 wrap; RST asserted same cycle as CALL -> PCOUT=RESET_PC, STK_EMPTY=1, STK_ERR=0.
